// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared FSM state type and default address width for mem_arb
package mem_arb_pkg;
   localparam int DEFAULT_AW = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      RESP  = 2'd3
   } state_t;
endpackage

// File: rtl/bit_mem.sv
// rtl/bit_mem.sv - 2**AW x 1-bit storage with registered read data, cleared on reset
module bit_mem
   import mem_arb_pkg::*;
#(
   parameter int AW = DEFAULT_AW
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          WE,
   input  logic [AW-1:0] ADDR,
   input  logic          DIN,
   output logic          DOUT
);

   logic [2**AW-1:0] mem;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         mem  <= '0;
         DOUT <= 1'b0;
      end else begin
         if (WE) begin
            mem[ADDR] <= DIN;
         end
         DOUT <= mem[ADDR];
      end
   end

endmodule

// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - two-requester round-robin arbiter in front of a shared bit_mem
module mem_arb
   import mem_arb_pkg::*;
#(
   parameter int AW = DEFAULT_AW
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          REQ0,
   input  logic          REQ1,
   input  logic          RW0,
   input  logic          RW1,
   input  logic [AW-1:0] ADDR0,
   input  logic [AW-1:0] ADDR1,
   input  logic          IN0,
   input  logic          IN1,
   output logic          GNT0,
   output logic          GNT1,
   output logic          ACK0,
   output logic          ACK1,
   output logic          OUT0,
   output logic          OUT1,
   output logic          BUSY
);

   state_t        state;
   state_t        state_nxt;
   logic          pri;
   logic          owner;
   logic          win;
   logic          win_rw;
   logic [AW-1:0] lat_addr;
   logic          lat_in;
   logic          out0_q;
   logic          out1_q;
   logic          dout;
   logic          done;

   always_comb begin
      win    = (REQ0 && REQ1) ? pri : REQ1;
      win_rw = win ? RW1 : RW0;
   end

   // The latched RW is carried by the WRITE/READ state itself.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (REQ0 || REQ1) state_nxt = win_rw ? WRITE : READ;
         WRITE:   state_nxt = IDLE;
         READ:    state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= IDLE;
         pri      <= 1'b0;
         owner    <= 1'b0;
         lat_addr <= '0;
         lat_in   <= 1'b0;
         out0_q   <= 1'b0;
         out1_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && (REQ0 || REQ1)) begin
            owner    <= win;
            lat_addr <= win ? ADDR1 : ADDR0;
            lat_in   <= win ? IN1 : IN0;
         end
         if (done) begin
            pri <= ~owner;
         end
         if (state == RESP) begin
            if (owner) out1_q <= dout;
            else       out0_q <= dout;
         end
      end
   end

   always_comb begin
      done = (state == WRITE) || (state == RESP);
      BUSY = (state != IDLE);
      GNT0 = BUSY && !owner;
      GNT1 = BUSY && owner;
      ACK0 = done && !owner;
      ACK1 = done && owner;
      // Read data is forwarded during RESP so it is valid alongside ACK.
      OUT0 = (state == RESP && !owner) ? dout : out0_q;
      OUT1 = (state == RESP && owner) ? dout : out1_q;
   end

   bit_mem #(.AW(AW)) u_mem (
      .CLK  (CLK),
      .RST  (RST),
      .WE   (state == WRITE),
      .ADDR (lat_addr),
      .DIN  (lat_in),
      .DOUT (dout)
   );

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - directed scoreboard bench for mem_arb
module tb_mem_arb;
   localparam int AW = 2;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          REQ0 = 1'b0, REQ1 = 1'b0, RW0 = 1'b0, RW1 = 1'b0, IN0 = 1'b0, IN1 = 1'b0;
   logic [AW-1:0] ADDR0 = '0, ADDR1 = '0;
   logic          GNT0, GNT1, ACK0, ACK1, OUT0, OUT1, BUSY;

   typedef struct {
      bit who;
      bit rw;
      bit data;
   } item_t;

   item_t sb[$];
   bit    model_mem[4];
   logic  exp_out0 = 1'b0;
   logic  exp_out1 = 1'b0;
   int    n_assert = 0;
   int    n_fail = 0;
   int    cyc = 0;

   mem_arb #(.AW(AW)) dut (
      .CLK(CLK), .RST(RST),
      .REQ0(REQ0), .REQ1(REQ1), .RW0(RW0), .RW1(RW1),
      .ADDR0(ADDR0), .ADDR1(ADDR1), .IN0(IN0), .IN1(IN1),
      .GNT0(GNT0), .GNT1(GNT1), .ACK0(ACK0), .ACK1(ACK1),
      .OUT0(OUT0), .OUT1(OUT1), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   initial forever begin
      @(posedge CLK);
      cyc++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every ACK and tracks both OUT values.
   initial forever begin
      item_t it;
      bit    w;
      @(negedge CLK);
      if (!RST) begin
         check("gnt_exclusive", {31'd0, GNT0 & GNT1}, 0);
         if (ACK0 || ACK1) begin
            w = ACK1;
            check("ack_exclusive", {31'd0, ACK0 & ACK1}, 0);
            check("sb_has_entry", {31'd0, sb.size() != 0}, 1);
            if (sb.size() != 0) begin
               it = sb.pop_front();
               check("ack_who", {31'd0, w}, {31'd0, it.who});
               check("gnt_with_ack", {31'd0, w ? GNT1 : GNT0}, 1);
               if (!it.rw) begin
                  if (it.who) exp_out1 = it.data;
                  else        exp_out0 = it.data;
               end
            end
         end
         check("out0", {31'd0, OUT0}, {31'd0, exp_out0});
         check("out1", {31'd0, OUT1}, {31'd0, exp_out1});
      end
   end

   task automatic push(input bit who, input bit rw, input logic [AW-1:0] addr, input bit din);
      item_t it;
      it.who  = who;
      it.rw   = rw;
      it.data = rw ? din : model_mem[addr];
      if (rw) model_mem[addr] = din;
      sb.push_back(it);
   endtask

   task automatic drive(input bit who, input bit rw, input logic [AW-1:0] addr, input bit din);
      if (who) begin REQ1 = 1'b1; RW1 = rw; ADDR1 = addr; IN1 = din; end
      else     begin REQ0 = 1'b1; RW0 = rw; ADDR0 = addr; IN0 = din; end
   endtask

   task automatic drop(input bit who);
      if (who) REQ1 = 1'b0;
      else     REQ0 = 1'b0;
   endtask

   task automatic wait_ack(input bit who, output int lat);
      lat = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge CLK);
         if (who ? ACK1 : ACK0) begin
            lat = i;
            break;
         end
      end
      check("ack_seen", {31'd0, lat != 0}, 1);
   endtask

   task automatic single(input bit who, input bit rw, input logic [AW-1:0] addr, input bit din);
      int lat;
      @(posedge CLK); #1;
      push(who, rw, addr, din);
      drive(who, rw, addr, din);
      @(posedge CLK); #1;
      drop(who);
      wait_ack(who, lat);
      check(rw ? "write_latency" : "read_latency", lat, rw ? 1 : 2);
   endtask

   task automatic contend(input bit rw0, input logic [AW-1:0] a0, input bit d0,
                          input bit rw1, input logic [AW-1:0] a1, input bit d1,
                          input bit first);
      int lat;
      @(posedge CLK); #1;
      if (first) begin push(1, rw1, a1, d1); push(0, rw0, a0, d0); end
      else       begin push(0, rw0, a0, d0); push(1, rw1, a1, d1); end
      drive(0, rw0, a0, d0);
      drive(1, rw1, a1, d1);
      @(posedge CLK); #1;
      check("contend_first_gnt", {31'd0, first ? GNT1 : GNT0}, 1);
      check("contend_loser_gnt", {31'd0, first ? GNT0 : GNT1}, 0);
      drop(first);
      wait_ack(first, lat);
      wait_ack(~first, lat);
      drop(~first);
   endtask

   task automatic model_reset();
      foreach (model_mem[i]) model_mem[i] = 1'b0;
      exp_out0 = 1'b0;
      exp_out1 = 1'b0;
      sb.delete();
   endtask

   initial begin
      int acks[3];
      int gnt0_seen;
      int lat;

      model_reset();
      #2;
      check("rst_gnt", {30'd0, GNT0, GNT1}, 0);
      check("rst_ack", {30'd0, ACK0, ACK1}, 0);
      check("rst_out", {30'd0, OUT0, OUT1}, 0);
      check("rst_busy", {31'd0, BUSY}, 0);
      #20 RST = 1'b0;

      // Contention from reset: 0 wins, then 1 reads what 0 wrote.
      contend(1, 0, 1, 0, 0, 0, 0);
      contend(0, 0, 0, 1, 0, 0, 0);

      single(0, 1, 2, 1);
      single(0, 0, 2, 0);

      // Requester 0 completed last, so requester 1 now has priority.
      contend(0, 3, 0, 1, 3, 1, 1);

      @(posedge CLK); #1;
      for (int k = 0; k < 3; k++) push(1, 0, 2, 0);
      drive(1, 0, 2, 0);
      gnt0_seen = 0;
      for (int k = 0; k < 3; k++) begin
         acks[k] = -100;
         for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (GNT0) gnt0_seen++;
            if (ACK1) begin
               acks[k] = cyc;
               break;
            end
         end
      end
      drop(1);
      check("b2b_gap0", acks[1] - acks[0], 3);
      check("b2b_gap1", acks[2] - acks[1], 3);
      check("b2b_no_gnt0", gnt0_seen, 0);

      // Leave PRI = 1 and address 3 = 1 so reset must clear both.
      single(0, 1, 3, 1);

      @(posedge CLK); #1;
      drive(0, 0, 2, 0);
      @(posedge CLK); #1;
      check("mid_read_busy", {31'd0, BUSY}, 1);
      RST = 1'b1;
      #1;
      check("mid_read_rst_gnt", {30'd0, GNT0, GNT1}, 0);
      check("mid_read_rst_ack", {30'd0, ACK0, ACK1}, 0);
      check("mid_read_rst_busy", {31'd0, BUSY}, 0);
      check("mid_read_rst_out", {30'd0, OUT0, OUT1}, 0);
      drop(0);
      model_reset();
      #1 RST = 1'b0;

      contend(0, 2, 0, 0, 3, 0, 0);
      single(0, 0, 2, 0);

      @(posedge CLK); #1;
      drive(0, 1, 1, 1);
      @(posedge CLK); #1;
      check("abort_in_write", {31'd0, GNT0 & ACK0}, 1);
      RST = 1'b1;
      #1;
      drop(0);
      model_reset();
      #1 RST = 1'b0;
      single(1, 0, 1, 0);
      single(0, 0, 1, 0);

      repeat (3) @(posedge CLK);
      check("sb_drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter: AW, default 2, address width; storage depth SHALL be 2**AW one-bit entries.
REQ-002 CLK  input  1  single clock; all state SHALL update on posedge CLK.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 REQ0 / REQ1  input  1  transaction request from requester 0 / 1.
REQ-005 RW0 / RW1  input  1  1 = write, 0 = read; stable while REQx high and ACKx low.
REQ-006 ADDR0 / ADDR1  input  AW  entry address; stable while REQx high and ACKx low.
REQ-007 IN0 / IN1  input  1  write data; stable while REQx high and ACKx low.
REQ-008 GNT0 / GNT1  output  1  requester x owns the storage for the current transaction.
REQ-009 ACK0 / ACK1  output  1  one-cycle completion pulse to requester x.
REQ-010 OUT0 / OUT1  output  1  read data returned to requester x.
REQ-011 BUSY  output  1  high whenever the FSM is not in IDLE.

Function
REQ-012 FSM states SHALL be IDLE, WRITE, READ, RESP.
REQ-013 In IDLE with any REQx high, the winner SHALL be chosen at the posedge and its RW, ADDR and IN latched into internal registers.
REQ-014 Arbitration SHALL be round-robin: a 1-bit priority pointer favours requester PRI; after a transaction for x completes, PRI SHALL become the other requester.
REQ-015 Only one requester high: it SHALL win regardless of PRI.
REQ-016 Both high: requester PRI SHALL win; the loser SHALL remain pending with no lost request.
REQ-017 Latched RW = 1: IDLE -> WRITE; the storage entry SHALL be written with latched IN at the end of the WRITE cycle; WRITE -> IDLE.
REQ-018 Latched RW = 0: IDLE -> READ (storage read, data registered at end of cycle) -> RESP -> IDLE.
REQ-019 GNTx SHALL be high in every WRITE, READ and RESP cycle of x's transaction, and low otherwise; at most one GNT high at any time.
REQ-020 ACKx SHALL be high exactly in the WRITE cycle (write) or the RESP cycle (read), one cycle per transaction.
REQ-021 Latency from the posedge sampling REQx in IDLE to ACKx high SHALL be 1 cycle for writes and 2 cycles for reads.
REQ-022 OUTx SHALL update only in x's RESP cycle and hold its value otherwise; the other requester's OUT SHALL be unaffected.
REQ-023 A requester SHALL be re-arbitrated if REQx is still high when the FSM returns to IDLE (back-to-back transactions allowed; no idle bubble beyond the IDLE cycle).
REQ-024 REQx dropping after grant SHALL NOT abort the transaction; it completes on latched values.
REQ-025 Address wrap is not possible; all 2**AW addresses SHALL be valid.
REQ-026 A write followed by a read of the same address (either requester) SHALL return the newly written value.

Reset
REQ-027 RST high SHALL immediately force IDLE, PRI = 0, all storage entries = 0, GNT0/1, ACK0/1, OUT0/1, BUSY = 0.
REQ-028 RST asserted in WRITE SHALL prevent the write from committing; RST asserted in READ/RESP SHALL suppress ACK and the OUT update.
REQ-029 After RST deasserts, the first arbitration SHALL occur at the first posedge with a REQ high.

Structure
REQ-030 Shared package mem_arb_pkg SHALL hold the state enum type and the default AW constant.
REQ-031 Storage SHALL be a sub-module bit_mem (AW parameter; CLK, RST, WE, ADDR, DIN, registered DOUT); arbitration and FSM stay in mem_arb.

Verification
REQ-032 Reset: RST pulse mid-READ -> same-cycle GNT/ACK/BUSY = 0, OUT0/1 = 0, next read of any address returns 0.
REQ-033 Single write/read: REQ0 write ADDR0 = 2, IN0 = 1 -> ACK0 one cycle after sampling; then REQ0 read ADDR0 = 2 -> ACK0 two cycles after sampling, OUT0 = 1, OUT1 unchanged.
REQ-034 Contention: REQ0 and REQ1 high together from reset -> requester 0 served first, requester 1 served next; repeat -> requester 0 served first again (PRI alternates correctly).
REQ-035 Cross-requester coherency: requester 1 writes ADDR = 3, IN = 1; requester 0 reads ADDR = 3 -> OUT0 = 1.
REQ-036 Back-to-back: REQ1 held high for 3 reads with REQ0 low -> ACK1 every 3 cycles, no spurious GNT0.
REQ-037 Abort-safety: RST asserted during WRITE of ADDR = 1, IN = 1 -> subsequent read of ADDR = 1 returns 0.
